// File: rtl/spi_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// vga_cmd_pkg
// Shared definitions for the SPI command sequencer: opcode encodings, the
// parser FSM state type and default sizes for the character-memory path and
// the configuration word.
// ---------------------------------------------------------------------------
package vga_cmd_pkg;

    // Opcode lives in bits [7:6] of the first byte of a command.
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_CFG  = 2'b01;
    localparam logic [1:0] OP_CHR  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam int          ADDR_W_DEF    = 11;
    localparam int          DATA_W_DEF    = 6;
    localparam logic [31:0] CFG_RESET_DEF = 32'hBFFC_0000;

    // One state per expected byte; every accepted byte advances one state.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG3,
        ST_CFG2,
        ST_CFG1,
        ST_CFG0,
        ST_CHRA1,
        ST_CHRA0,
        ST_CHRD
    } state_t;

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// spi_cmd_sequencer_if
// Byte stream in from the SPI peripheral and character-memory write bus out.
//   rx_valid / rx_byte         : one-cycle byte strobe from the SPI block
//   char_wr_en/addr/data       : character-memory write port
// Modports:
//   master : SPI/video side (drives bytes, consumes char writes)
//   slave  : sequencer side (consumes bytes, drives char writes)
// ---------------------------------------------------------------------------
interface spi_cmd_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 6
);
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              char_wr_en;
    logic [ADDR_W-1:0] char_wr_addr;
    logic [DATA_W-1:0] char_wr_data;

    modport master (
        output rx_valid, rx_byte,
        input  char_wr_en, char_wr_addr, char_wr_data
    );

    modport slave (
        input  rx_valid, rx_byte,
        output char_wr_en, char_wr_addr, char_wr_data
    );
endinterface

// File: rtl/spi_cmd_sequencer_char_wr_fifo.sv
// ---------------------------------------------------------------------------
// char_wr_fifo
// Synchronous FIFO holding pending character-memory writes {addr,data}.
// A push while full is accepted only if a pop happens in the same cycle.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_push, i_din   : enqueue request and entry
//   i_pop           : dequeue request (ignored when empty)
//   o_dout          : head entry (valid when !o_empty)
//   o_full, o_empty : occupancy flags
// ---------------------------------------------------------------------------
module char_wr_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    // Extra MSB on the pointers distinguishes full from empty.
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_dout    = r_mem[r_rptr[AW-1:0]];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// spi_cmd_sequencer
// Parses SPI command bytes into display-configuration updates and
// character-memory writes, and defers both into vertical blanking so the
// visible frame never tears. Owns the 32-bit configuration register.
//
// Optional feature macro: CMD_TIMEOUT_EN
//   defined   : a partial command idle for TIMEOUT_CYCLES cycles is dropped
//   undefined : a partial command waits indefinitely
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_ena           : enable; when low incoming bytes are ignored
//   i_vblank        : vertical blanking level
//   bus (slave)     : rx byte stream in, character write bus out
//   o_cfg_out       : committed configuration word
//   o_cfg_pending   : shadow word waiting for next blanking
//   o_busy          : command in progress or writes queued
//   o_err_opcode    : sticky, reserved opcode seen
//   o_err_overflow  : sticky, char write dropped on full queue
// ---------------------------------------------------------------------------
module spi_cmd_sequencer
    import vga_cmd_pkg::*;
#(
    parameter logic [31:0] CFG_RESET  = CFG_RESET_DEF,
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int          FIFO_DEPTH = 4
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_ena,
    input  logic                 i_vblank,
    spi_cmd_sequencer_if.slave   bus,
    output logic [31:0]          o_cfg_out,
    output logic                 o_cfg_pending,
    output logic                 o_busy,
    output logic                 o_err_opcode,
    output logic                 o_err_overflow
);
    localparam int FW = ADDR_W + DATA_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_acc;
    logic              w_cfg_done;
    logic              w_chr_done;
    logic              w_nop_clr;
    logic              w_rsvd;

    logic [23:0]       r_asm;        // first three CFG bytes, MSB first
    logic [10:0]       r_addr_raw;   // {addr[10:8], addr[7:0]} from CHR bytes
    logic [31:0]       r_shadow;
    logic [31:0]       r_cfg;
    logic              r_pending;
    logic              r_vblank_q;
    logic              r_err_op;
    logic              r_err_ovf;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_vrise;
    logic [31:0]       w_cfg_word;
    logic [FW-1:0]     w_chr_entry;
    logic [FW-1:0]     w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;

    assign w_acc       = i_ena & bus.rx_valid;
    assign w_vrise     = i_vblank & ~r_vblank_q;
    assign w_cfg_word  = {r_asm, bus.rx_byte};
    assign w_chr_entry = {ADDR_W'(r_addr_raw), bus.rx_byte[DATA_W-1:0]};

`ifdef CMD_TIMEOUT_EN
    localparam int             TO_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;

    // Counts idle cycles spent mid-command; fires on the last one.
    assign w_timeout = ~w_acc && (r_state != ST_IDLE) && (r_to_cnt == TO_MAX);

    always_ff @(posedge clk) begin
        if (rst || w_acc || w_timeout)
            r_to_cnt <= '0;
        else if (r_state != ST_IDLE)
            r_to_cnt <= r_to_cnt + 1'b1;
    end
`endif

    // ---------------- parser FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cfg_done  = 1'b0;
        w_chr_done  = 1'b0;
        w_nop_clr   = 1'b0;
        w_rsvd      = 1'b0;
        if (w_acc) begin
            unique case (r_state)
                ST_IDLE: begin
                    unique case (bus.rx_byte[7:6])
                        OP_NOP:  w_nop_clr   = bus.rx_byte[0];
                        OP_CFG:  w_state_nxt = ST_CFG3;
                        OP_CHR:  w_state_nxt = ST_CHRA1;
                        OP_RSVD: w_rsvd      = 1'b1;
                    endcase
                end
                ST_CFG3:  w_state_nxt = ST_CFG2;
                ST_CFG2:  w_state_nxt = ST_CFG1;
                ST_CFG1:  w_state_nxt = ST_CFG0;
                ST_CFG0: begin
                    w_state_nxt = ST_IDLE;
                    w_cfg_done  = 1'b1;
                end
                ST_CHRA1: w_state_nxt = ST_CHRA0;
                ST_CHRA0: w_state_nxt = ST_CHRD;
                ST_CHRD: begin
                    w_state_nxt = ST_IDLE;
                    w_chr_done  = 1'b1;
                end
            endcase
        end
`ifdef CMD_TIMEOUT_EN
        else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
`endif
    end

    // ---------------- byte capture ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm      <= '0;
            r_addr_raw <= '0;
        end else if (w_acc) begin
            case (r_state)
                ST_CFG3:  r_asm[23:16]     <= bus.rx_byte;
                ST_CFG2:  r_asm[15:8]      <= bus.rx_byte;
                ST_CFG1:  r_asm[7:0]       <= bus.rx_byte;
                ST_CHRA1: r_addr_raw[10:8] <= bus.rx_byte[2:0];
                ST_CHRA0: r_addr_raw[7:0]  <= bus.rx_byte;
                default: ;
            endcase
        end
    end

    // ---------------- config shadow / commit ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblank_q <= 1'b0;
            r_shadow   <= CFG_RESET;
            r_cfg      <= CFG_RESET;
            r_pending  <= 1'b0;
        end else begin
            r_vblank_q <= i_vblank;
            if (w_cfg_done) begin
                r_shadow <= w_cfg_word;
                // Word completing on the blanking edge goes straight out.
                if (w_vrise) begin
                    r_cfg     <= w_cfg_word;
                    r_pending <= 1'b0;
                end else begin
                    r_pending <= 1'b1;
                end
            end else if (w_vrise && r_pending) begin
                r_cfg     <= r_shadow;
                r_pending <= 1'b0;
            end
        end
    end

    // ---------------- char write queue ----------------
    assign w_pop  = i_vblank & ~w_empty;
    assign w_push = w_chr_done;

    char_wr_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_chr_entry),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Address/data hold their last value between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_pop;
            if (w_pop) begin
                r_wr_addr <= w_head[FW-1:DATA_W];
                r_wr_data <= w_head[DATA_W-1:0];
            end
        end
    end

    // ---------------- sticky errors ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_op  <= 1'b0;
            r_err_ovf <= 1'b0;
        end else if (w_nop_clr) begin
            r_err_op  <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_rsvd) r_err_op <= 1'b1;
            // Full queue only drops when nothing leaves this cycle.
            if (w_push && w_full && !w_pop) r_err_ovf <= 1'b1;
        end
    end

    assign o_cfg_out        = r_cfg;
    assign o_cfg_pending    = r_pending;
    assign o_busy           = (r_state != ST_IDLE) | ~w_empty;
    assign o_err_opcode     = r_err_op;
    assign o_err_overflow   = r_err_ovf;
    assign bus.char_wr_en   = r_wr_en;
    assign bus.char_wr_addr = r_wr_addr;
    assign bus.char_wr_data = r_wr_data;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
module tb_spi_cmd_sequencer;
    localparam int AW    = 11;
    localparam int DW    = 6;
    localparam int DEPTH = 4;
`ifdef CMD_TIMEOUT_EN
    localparam int TO    = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        vblank;
    logic [31:0] cfg_out;
    logic        cfg_pending, busy, err_opcode, err_overflow;

    spi_cmd_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    spi_cmd_sequencer #(
        .CFG_RESET  (32'hBFFC_0000),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
`ifdef CMD_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_ena          (ena),
        .i_vblank       (vblank),
        .bus            (bus.slave),
        .o_cfg_out      (cfg_out),
        .o_cfg_pending  (cfg_pending),
        .o_busy         (busy),
        .o_err_opcode   (err_opcode),
        .o_err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Commands are tracked as a list of collected bytes; the write queue is
    // a plain queue of {addr,data}.
    logic [7:0]  m_cmd[$];
    logic [16:0] m_fifo[$];
    logic [31:0] m_shadow, m_cfg;
    bit          m_pend, m_vbq, m_eop, m_eovf, m_wen;
    logic [10:0] m_addr;
    logic [5:0]  m_data;
    int          m_idle;

    task automatic model_reset();
        m_cmd.delete();
        m_fifo.delete();
        m_shadow = 32'hBFFC_0000;
        m_cfg    = 32'hBFFC_0000;
        m_pend = 0; m_vbq = 0; m_eop = 0; m_eovf = 0; m_wen = 0;
        m_addr = '0; m_data = '0; m_idle = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit vb, input bit en);
        bit          acc, vrise, pop, cfg_done, chr_done;
        logic [31:0] word;
        logic [16:0] ent;
        logic [16:0] head;
        acc = v & en;
        vrise = vb & ~m_vbq;
        m_vbq = vb;
        pop = vb && (m_fifo.size() > 0);
        cfg_done = 0; chr_done = 0; word = '0; ent = '0;
        if (acc) begin
            if (m_cmd.size() == 0) begin
                case (b[7:6])
                    2'd0: if (b[0]) begin m_eop = 0; m_eovf = 0; end
                    2'd3: m_eop = 1;
                    default: m_cmd.push_back(b);
                endcase
            end else begin
                m_cmd.push_back(b);
                if (m_cmd[0][7:6] == 2'd1 && m_cmd.size() == 5) begin
                    cfg_done = 1;
                    word = {m_cmd[1], m_cmd[2], m_cmd[3], m_cmd[4]};
                    m_cmd.delete();
                end else if (m_cmd[0][7:6] == 2'd2 && m_cmd.size() == 4) begin
                    chr_done = 1;
                    ent = {m_cmd[1][2:0], m_cmd[2], m_cmd[3][5:0]};
                    m_cmd.delete();
                end
            end
        end
`ifdef CMD_TIMEOUT_EN
        if (!acc && m_cmd.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_cmd.delete();
                m_idle = 0;
            end
        end else begin
            m_idle = 0;
        end
`endif
        if (cfg_done) begin
            m_shadow = word;
            if (vrise) begin m_cfg = word; m_pend = 0; end
            else m_pend = 1;
        end else if (vrise && m_pend) begin
            m_cfg = m_shadow;
            m_pend = 0;
        end
        m_wen = pop;
        if (pop) begin
            head = m_fifo.pop_front();
            m_addr = head[16:6];
            m_data = head[5:0];
        end
        if (chr_done) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(ent);
            else m_eovf = 1;
        end
    endtask

    task automatic check_model();
        chk("cfg_out", cfg_out, m_cfg);
        chk("cfg_pending", cfg_pending, 32'(m_pend));
        chk("char_wr_en", bus.char_wr_en, 32'(m_wen));
        chk("char_wr_addr", bus.char_wr_addr, 32'(m_addr));
        chk("char_wr_data", bus.char_wr_data, 32'(m_data));
        chk("busy", busy, 32'((m_cmd.size() > 0) || (m_fifo.size() > 0)));
        chk("err_opcode", err_opcode, 32'(m_eop));
        chk("err_overflow", err_overflow, 32'(m_eovf));
    endtask

    // One clock: drive at negedge, step model, compare at following negedge.
    task automatic cyc(input bit v, input logic [7:0] b, input bit vb, input bit en);
        bus.rx_valid = v;
        bus.rx_byte  = b;
        vblank       = vb;
        ena          = en;
        model_step(v, b, vb, en);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b, 1'b0, 1'b1);
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  b;
        bit          vb;
        logic [31:0] cfg;
        bit          pend;
        bit          wen;
        logic [10:0] addr;
        logic [5:0]  data;
        bit          busy;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int nwr;
        bit vb_r;
        rst = 1'b1; ena = 1'b1; vblank = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_byte = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst cfg_out", cfg_out, 32'hBFFC_0000);
        chk("rst pending", cfg_pending, 0);
        chk("rst wr_en", bus.char_wr_en, 0);
        chk("rst busy", busy, 0);
        chk("rst errs", {err_opcode, err_overflow}, 0);
        chk("rst addr/data", {bus.char_wr_addr, bus.char_wr_data}, 0);

        // Idle vblank pulses: nothing should move.
        for (int p = 0; p < 3; p++) begin
            repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b1);
            repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        end
        chk("idle cfg_out", cfg_out, 32'hBFFC_0000);

        // ---------------- table vectors ----------------
        tbl[0]  = '{1'b1, 8'h40, 1'b0, 32'hBFFC_0000, 1'b0, 1'b0, 11'h000, 6'h00, 1'b1};
        tbl[1]  = '{1'b1, 8'h12, 1'b0, 32'hBFFC_0000, 1'b0, 1'b0, 11'h000, 6'h00, 1'b1};
        tbl[2]  = '{1'b1, 8'h34, 1'b0, 32'hBFFC_0000, 1'b0, 1'b0, 11'h000, 6'h00, 1'b1};
        tbl[3]  = '{1'b1, 8'h56, 1'b0, 32'hBFFC_0000, 1'b0, 1'b0, 11'h000, 6'h00, 1'b1};
        tbl[4]  = '{1'b1, 8'h78, 1'b0, 32'hBFFC_0000, 1'b1, 1'b0, 11'h000, 6'h00, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 11'h000, 6'h00, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 11'h000, 6'h00, 1'b0};
        tbl[7]  = '{1'b1, 8'h80, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 11'h000, 6'h00, 1'b1};
        tbl[8]  = '{1'b1, 8'h05, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 11'h000, 6'h00, 1'b1};
        tbl[9]  = '{1'b1, 8'h2A, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 11'h000, 6'h00, 1'b1};
        tbl[10] = '{1'b1, 8'h3F, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 11'h000, 6'h00, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 11'h52A, 6'h3F, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 11'h52A, 6'h3F, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 11'h52A, 6'h3F, 1'b0};
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].v, tbl[i].b, tbl[i].vb, 1'b1);
            chk($sformatf("tbl%0d cfg", i), cfg_out, tbl[i].cfg);
            chk($sformatf("tbl%0d pend", i), cfg_pending, 32'(tbl[i].pend));
            chk($sformatf("tbl%0d wen", i), bus.char_wr_en, 32'(tbl[i].wen));
            chk($sformatf("tbl%0d addr", i), bus.char_wr_addr, 32'(tbl[i].addr));
            chk($sformatf("tbl%0d data", i), bus.char_wr_data, 32'(tbl[i].data));
            chk($sformatf("tbl%0d busy", i), busy, 32'(tbl[i].busy));
        end

        // ---------------- overflow: five CHR into four slots ----------------
        for (int k = 0; k < 5; k++) begin
            send(8'h80);
            send(8'hF9);                       // only [2:0]=1 matters
            send(8'(8'h10 + k));
            send(8'(8'hC0 | (k + 1)));         // data bits [5:0]
        end
        chk("ovf sticky", err_overflow, 1);
        nwr = 0;
        for (int c = 0; c < 6; c++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b1);
            if (bus.char_wr_en) begin
                chk($sformatf("drain%0d addr", nwr), bus.char_wr_addr, 32'(11'h110 + nwr));
                chk($sformatf("drain%0d data", nwr), bus.char_wr_data, 32'(nwr + 1));
                nwr++;
            end
        end
        chk("drain count", nwr, 4);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        send(8'h01);
        chk("nop clears ovf", err_overflow, 0);

        // ---------------- reserved opcode then CFG ----------------
        send(8'hC0);
        chk("rsvd err", err_opcode, 1);
        chk("rsvd idle", busy, 0);
        send(8'h40); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        chk("rsvd cfg pend", cfg_pending, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("rsvd cfg commit", cfg_out, 32'hDEAD_BEEF);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // ---------------- completion on the blanking edge ----------------
        send(8'h40); send(8'h11); send(8'h22); send(8'h33);
        cyc(1'b1, 8'h44, 1'b1, 1'b1);
        chk("edge cfg", cfg_out, 32'h1122_3344);
        chk("edge pend", cfg_pending, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // ---------------- ena low drops bytes ----------------
        cyc(1'b1, 8'h40, 1'b0, 1'b0);
        chk("ena0 busy", busy, 0);

`ifdef CMD_TIMEOUT_EN
        send(8'h40); send(8'hAA);
        repeat (TO - 1) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("to before", busy, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("to after", busy, 0);
        send(8'h40); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("to fresh cfg", cfg_out, 32'h0102_0304);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
`endif

        // ---------------- randomized vs model ----------------
        vb_r = 1'b0;
        for (int n = 0; n < 800; n++) begin
            logic [7:0] rb;
            if ($urandom_range(0, 9) == 0) vb_r = ~vb_r;
            rb = 8'($urandom);
            cyc(1'($urandom_range(0, 1)), rb, vb_r, ($urandom_range(0, 9) != 0));
        end

        // Reset mid-traffic returns everything to reset values.
        send(8'h40); send(8'h99);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rst2 cfg", cfg_out, 32'hBFFC_0000);
        chk("rst2 busy", busy, 0);
        chk("rst2 pend", cfg_pending, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
